imem_port_arbiter: RTL and testbench
====================================

# imem_port_arbiter

Shares the single-port instruction memory between the core's fetch stage and a program loader/debug port. It grants at most one access per cycle and drives the memory's word address, write enable and write data. It registers the read data into a one-cycle-latency response per requester. A starvation counter and a loader lock mode let programs be written or inspected while the core is stalled or running.

## Interface
- ADDR_W, 32, byte-address width of both request ports
- DATA_W, 32, data width
- DEPTH, 1024, memory depth in words; word index width IDX_W = clog2(DEPTH)
- MAX_WAIT, 4, consecutive cycles a pending loader request may lose before it gets priority (1..15)
- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- if_req_valid  in  1  fetch request
- if_req_addr  in  ADDR_W  fetch byte address
- if_req_ready  out  1  fetch request accepted this cycle
- if_rsp_valid  out  1  fetch response valid
- if_rsp_data  out  DATA_W  fetched instruction
- if_stall  out  1  high while in LOCK
- ld_lock  in  1  loader requests exclusive ownership
- ld_req_valid  in  1  loader request
- ld_req_we  in  1  1 = write, 0 = read
- ld_req_addr  in  ADDR_W  loader byte address
- ld_req_wdata  in  DATA_W  loader write data
- ld_req_ready  out  1  loader request accepted this cycle
- ld_rsp_valid  out  1  loader response valid (reads and writes)
- ld_rsp_data  out  DATA_W  read data; 0 for writes
- mem_addr  out  IDX_W  word index to memory
- mem_we  out  1  write strobe, committed at clock edge
- mem_wdata  out  DATA_W  write data
- mem_rdata  in  DATA_W  combinational read data for mem_addr

## Operation
- FSM states are RUN and LOCK; reset enters RUN.
- RUN -> LOCK at the edge where ld_lock=1. LOCK -> RUN at the edge where ld_lock=0. if_stall = (state==LOCK).
- Accept rule: a request is accepted when valid && ready in the same cycle. ready is combinational from state, the other port's valid, and wait_cnt.
- Grant in RUN:
  - Loader wins if ld_req_valid && (wait_cnt==MAX_WAIT || !if_req_valid).
  - Otherwise fetch wins if if_req_valid.
- Grant in LOCK: loader only. if_req_ready=0.
- wait_cnt (4 bits):
  - +1 on a cycle with ld_req_valid && !ld_req_ready, saturating at MAX_WAIT.
  - Cleared on loader accept, or when ld_req_valid=0.
- Address: index = addr[IDX_W+1:2]. addr[1:0] is ignored.
- Out of range (addr[ADDR_W-1:IDX_W+2] != 0): the request is accepted. Writes are suppressed (mem_we=0). The read response data is 0.
- mem_addr/mem_wdata follow the granted request. With no grant, mem_addr holds its last value and mem_we=0.
- Responses are not backpressured; requesters must take them.

## Timing
- Response latency is 1 cycle: accept at edge N gives rsp_valid=1 during cycle N+1. Data is mem_rdata registered at edge N.
- Back-to-back accepts on one port give one response per cycle, with full throughput.
- A loader write is visible to a fetch accepted in the next cycle.
- Both valids together: exactly one is granted, and the loser's ready=0. The loser must hold its request stable until accepted.
- ld_lock rising while a fetch is accepted the same cycle: that fetch completes and its response still issues in the next cycle. The next cycle is LOCK.
- Reset (any time, asynchronous):
  - state=RUN, wait_cnt=0.
  - All rsp_valid=0, rsp_data=0, mem_we=0, mem_addr=0, mem_wdata=0, if_stall=0.
  - An outstanding response is dropped.

## Structure
- Package imem_arb_pkg holds:
  - the state enum {RUN, LOCK};
  - the grant encoding {GNT_NONE, GNT_IF, GNT_LD};
  - the default DEPTH/MAX_WAIT constants;
  - an addr-to-index/in-range helper function.
- One natural sub-module, imem_rsp_reg: a per-port response register (valid, data, zero-on-write/out-of-range). It is instantiated twice.

## Test plan
- Fetch only, addrs 0,4,8 on consecutive cycles, memory preloaded with words 0xE3A01A01, 0xE3A00014, 0xE3A02103 -> same words on if_rsp_data in cycles +1,+2,+3, with if_req_ready constantly 1.
- Both valid continuously, MAX_WAIT=4 -> fetch is granted 4 cycles, then the loader is granted on the 5th, and wait_cnt returns to 0. The pattern repeats.
- ld_lock=1, loader writes 0xDEADBEEF to addr 0x40, then reads it back -> if_stall=1 and if_req_ready=0 throughout. ld_rsp_data=0 for the write, then 0xDEADBEEF for the read. Release lock, then fetch addr 0x40 returns 0xDEADBEEF.
- Loader write to addr 0x1000 (index 1024, out of range) -> accepted, mem_we=0, ld_rsp_valid=1 with data 0. The memory is unchanged.
- Misaligned fetch addr 0x43 -> returns the word at index 16.
- Assert rst for one cycle immediately after a fetch accept -> no if_rsp_valid. All outputs are 0 and state=RUN. The next fetch behaves normally.

Source files
------------

// File: rtl/imem_arb_pkg.sv
// Shared types and helpers for the instruction-memory port arbiter.
// Covers the FSM states, the grant encoding and byte-address decoding.
package imem_arb_pkg;

    typedef enum logic {
        RUN  = 1'b0,
        LOCK = 1'b1
    } arb_state_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_IF   = 2'd1,
        GNT_LD   = 2'd2
    } arb_grant_t;

    localparam int DEF_DEPTH    = 1024;
    localparam int DEF_MAX_WAIT = 4;
    localparam int MAX_ADDR_W   = 64;

    typedef logic [MAX_ADDR_W-1:0] wide_addr_t;

    // Byte address to word index; the low two bits are dropped.
    function automatic wide_addr_t addr_to_index(input wide_addr_t addr, input int idx_w);
        wide_addr_t mask;
        mask = (wide_addr_t'(1) << idx_w) - wide_addr_t'(1);
        return (addr >> 2) & mask;
    endfunction

    function automatic logic addr_in_range(input wide_addr_t addr, input int idx_w);
        return (addr >> (idx_w + 2)) == '0;
    endfunction

endpackage

// File: rtl/imem_rsp_reg.sv
// One-cycle response register for a single requester.
// The data is forced to zero for writes and for out-of-range reads.
module imem_rsp_reg #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              accept,
    input  logic              zero,
    input  logic [DATA_W-1:0] rdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= accept;
            if (accept) begin
                rsp_data <= zero ? '0 : rdata;
            end
        end
    end

endmodule

// File: rtl/imem_port_arbiter.sv
// Shares the single-port instruction memory between fetch and the loader/debug port.
// The loader gets priority after MAX_WAIT lost cycles, or exclusive access while locked.
module imem_port_arbiter
    import imem_arb_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int MAX_WAIT = DEF_MAX_WAIT,
    localparam int IDX_W   = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_valid,
    input  logic [ADDR_W-1:0] if_req_addr,
    output logic              if_req_ready,
    output logic              if_rsp_valid,
    output logic [DATA_W-1:0] if_rsp_data,
    output logic              if_stall,
    input  logic              ld_lock,
    input  logic              ld_req_valid,
    input  logic              ld_req_we,
    input  logic [ADDR_W-1:0] ld_req_addr,
    input  logic [DATA_W-1:0] ld_req_wdata,
    output logic              ld_req_ready,
    output logic              ld_rsp_valid,
    output logic [DATA_W-1:0] ld_rsp_data,
    output logic [IDX_W-1:0]  mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_t        state, state_nx;
    arb_grant_t        grant;
    logic [3:0]        wait_cnt;
    logic              ld_pri;
    logic [IDX_W-1:0]  addr_q;
    logic [DATA_W-1:0] wdata_q;

    wide_addr_t        if_wide, ld_wide;
    logic [IDX_W-1:0]  if_idx, ld_idx;
    logic              if_in_range, ld_in_range;

    assign if_wide     = wide_addr_t'(if_req_addr);
    assign ld_wide     = wide_addr_t'(ld_req_addr);
    assign if_idx      = IDX_W'(addr_to_index(if_wide, IDX_W));
    assign ld_idx      = IDX_W'(addr_to_index(ld_wide, IDX_W));
    assign if_in_range = addr_in_range(if_wide, IDX_W);
    assign ld_in_range = addr_in_range(ld_wide, IDX_W);

    assign ld_pri   = (wait_cnt == 4'(MAX_WAIT));
    assign if_stall = (state == LOCK);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        grant        = GNT_NONE;
        if_req_ready = 1'b0;
        ld_req_ready = 1'b0;
        case (state)
            RUN: begin
                state_nx     = ld_lock ? LOCK : RUN;
                ld_req_ready = ld_pri || !if_req_valid;
                if_req_ready = !(ld_req_valid && ld_pri);
                if (ld_req_valid && ld_req_ready) begin
                    grant = GNT_LD;
                end else if (if_req_valid && if_req_ready) begin
                    grant = GNT_IF;
                end
            end
            LOCK: begin
                state_nx     = ld_lock ? LOCK : RUN;
                ld_req_ready = 1'b1;
                if (ld_req_valid) begin
                    grant = GNT_LD;
                end
            end
            default: state_nx = RUN;
        endcase
    end

    // Counts cycles the loader has been kept waiting; any idle or accepted cycle restarts it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= 4'd0;
        end else if (!ld_req_valid || ld_req_ready) begin
            wait_cnt <= 4'd0;
        end else if (!ld_pri) begin
            wait_cnt <= wait_cnt + 4'd1;
        end
    end

    // Without a grant the memory bus keeps its previous address and data.
    always_comb begin
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        mem_we    = 1'b0;
        case (grant)
            GNT_IF: mem_addr = if_idx;
            GNT_LD: begin
                mem_addr  = ld_idx;
                mem_wdata = ld_req_wdata;
                mem_we    = ld_req_we && ld_in_range;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (grant != GNT_NONE) begin
            addr_q  <= mem_addr;
            wdata_q <= mem_wdata;
        end
    end

    imem_rsp_reg #(.DATA_W(DATA_W)) u_if_rsp (
        .clk       (clk),
        .rst       (rst),
        .accept    (grant == GNT_IF),
        .zero      (!if_in_range),
        .rdata     (mem_rdata),
        .rsp_valid (if_rsp_valid),
        .rsp_data  (if_rsp_data)
    );

    imem_rsp_reg #(.DATA_W(DATA_W)) u_ld_rsp (
        .clk       (clk),
        .rst       (rst),
        .accept    (grant == GNT_LD),
        .zero      (ld_req_we || !ld_in_range),
        .rdata     (mem_rdata),
        .rsp_valid (ld_rsp_valid),
        .rsp_data  (ld_rsp_data)
    );

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Self-checking bench for imem_port_arbiter: directed scenarios followed by randomized traffic
// compared against a behavioural model of the arbitration, memory and response rules.
module tb_imem_port_arbiter;

    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 32;
    localparam int DEPTH    = 1024;
    localparam int IDX_W    = 10;
    localparam int MAX_WAIT = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              if_req_valid;
    logic [ADDR_W-1:0] if_req_addr;
    logic              if_req_ready;
    logic              if_rsp_valid;
    logic [DATA_W-1:0] if_rsp_data;
    logic              if_stall;
    logic              ld_lock;
    logic              ld_req_valid;
    logic              ld_req_we;
    logic [ADDR_W-1:0] ld_req_addr;
    logic [DATA_W-1:0] ld_req_wdata;
    logic              ld_req_ready;
    logic              ld_rsp_valid;
    logic [DATA_W-1:0] ld_rsp_data;
    logic [IDX_W-1:0]  mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    imem_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .if_req_valid (if_req_valid),
        .if_req_addr  (if_req_addr),
        .if_req_ready (if_req_ready),
        .if_rsp_valid (if_rsp_valid),
        .if_rsp_data  (if_rsp_data),
        .if_stall     (if_stall),
        .ld_lock      (ld_lock),
        .ld_req_valid (ld_req_valid),
        .ld_req_we    (ld_req_we),
        .ld_req_addr  (ld_req_addr),
        .ld_req_wdata (ld_req_wdata),
        .ld_req_ready (ld_req_ready),
        .ld_rsp_valid (ld_rsp_valid),
        .ld_rsp_data  (ld_rsp_data),
        .mem_addr     (mem_addr),
        .mem_we       (mem_we),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    always #5 clk = ~clk;

    // Instruction memory attached to the DUT, with a preload path used during reset.
    logic [DATA_W-1:0] tb_mem [DEPTH];
    logic              pl_en;
    logic [IDX_W-1:0]  pl_idx;
    logic [DATA_W-1:0] pl_data;

    assign mem_rdata = tb_mem[mem_addr];

    always @(posedge clk) begin
        if (pl_en) tb_mem[pl_idx] <= pl_data;
        else if (mem_we) tb_mem[mem_addr] <= mem_wdata;
    end

    // Reference model state.
    logic [DATA_W-1:0] ref_mem [DEPTH];
    int                lose;
    bit                locked;
    bit                exp_if_v, exp_ld_v;
    logic [DATA_W-1:0] exp_if_d, exp_ld_d;
    bit                if_acc, ld_acc;
    int                checks = 0;
    int                errors = 0;

    logic [31:0] words [3];
    logic [31:0] saved;

    function automatic bit in_range(input logic [31:0] a);
        return a < 32'(DEPTH * 4);
    endfunction

    function automatic int word_of(input logic [31:0] a);
        return int'((a / 32'd4) % 32'(DEPTH));
    endfunction

    function automatic logic [31:0] rand_addr();
        if ($urandom_range(0, 9) == 0) return $urandom | 32'h0000_1000;
        return 32'($urandom_range(0, 31) * 4 + $urandom_range(0, 3));
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle with the current inputs: checks combinational outputs mid-cycle,
    // advances the model, then checks the responses just after the edge.
    task automatic applyStimulus();
        bit ld_win, if_win;
        int w;
        @(negedge clk);
        if (locked) begin
            ld_win = ld_req_valid;
            if_win = 1'b0;
        end else begin
            ld_win = ld_req_valid && (lose >= MAX_WAIT || !if_req_valid);
            if_win = if_req_valid && !ld_win;
        end
        checkOutput("if_stall", 32'(if_stall), 32'(locked));
        if (if_req_valid || locked) checkOutput("if_req_ready", 32'(if_req_ready), 32'(if_win));
        if (ld_req_valid) checkOutput("ld_req_ready", 32'(ld_req_ready), 32'(ld_win));
        checkOutput("mem_we", 32'(mem_we), 32'(ld_win && ld_req_we && in_range(ld_req_addr)));
        if (if_win) checkOutput("mem_addr_if", 32'(mem_addr), 32'(word_of(if_req_addr)));
        if (ld_win) checkOutput("mem_addr_ld", 32'(mem_addr), 32'(word_of(ld_req_addr)));
        if (ld_win && ld_req_we) checkOutput("mem_wdata", mem_wdata, ld_req_wdata);

        exp_if_v = if_win;
        if (if_win) begin
            w = word_of(if_req_addr);
            exp_if_d = in_range(if_req_addr) ? ref_mem[w] : 32'd0;
        end
        exp_ld_v = ld_win;
        if (ld_win) begin
            w = word_of(ld_req_addr);
            exp_ld_d = (ld_req_we || !in_range(ld_req_addr)) ? 32'd0 : ref_mem[w];
            if (ld_req_we && in_range(ld_req_addr)) ref_mem[w] = ld_req_wdata;
        end
        lose   = (ld_req_valid && !ld_win) ? ((lose + 1 > MAX_WAIT) ? MAX_WAIT : lose + 1) : 0;
        locked = ld_lock;
        if_acc = if_win;
        ld_acc = ld_win;

        @(posedge clk);
        #1;
        checkOutput("if_rsp_valid", 32'(if_rsp_valid), 32'(exp_if_v));
        if (exp_if_v) checkOutput("if_rsp_data", if_rsp_data, exp_if_d);
        checkOutput("ld_rsp_valid", 32'(ld_rsp_valid), 32'(exp_ld_v));
        if (exp_ld_v) checkOutput("ld_rsp_data", ld_rsp_data, exp_ld_d);
    endtask

    initial begin
        words[0] = 32'hE3A01A01;
        words[1] = 32'hE3A00014;
        words[2] = 32'hE3A02103;
        rst = 1'b1; ld_lock = 1'b0;
        if_req_valid = 1'b0; if_req_addr = '0;
        ld_req_valid = 1'b0; ld_req_we = 1'b0; ld_req_addr = '0; ld_req_wdata = '0;
        pl_en = 1'b0; pl_idx = '0; pl_data = '0;

        // Preload memory while the DUT sits in reset.
        for (int i = 0; i < DEPTH; i++) begin
            pl_en   = 1'b1;
            pl_idx  = IDX_W'(i);
            pl_data = (i < 3) ? words[i] : $urandom;
            ref_mem[i] = pl_data;
            @(posedge clk);
            #1;
        end
        pl_en = 1'b0;
        checkOutput("rst_if_rsp_valid", 32'(if_rsp_valid), 32'd0);
        checkOutput("rst_ld_rsp_valid", 32'(ld_rsp_valid), 32'd0);
        checkOutput("rst_if_rsp_data", if_rsp_data, 32'd0);
        checkOutput("rst_ld_rsp_data", ld_rsp_data, 32'd0);
        checkOutput("rst_mem_addr", 32'(mem_addr), 32'd0);
        checkOutput("rst_mem_we", 32'(mem_we), 32'd0);
        checkOutput("rst_mem_wdata", mem_wdata, 32'd0);
        checkOutput("rst_if_stall", 32'(if_stall), 32'd0);
        rst = 1'b0;
        lose = 0; locked = 1'b0; exp_if_v = 1'b0; exp_ld_v = 1'b0;

        $display("[TB] fetch stream 0,4,8");
        for (int i = 0; i < 3; i++) begin
            if_req_valid = 1'b1;
            if_req_addr  = 32'(i * 4);
            applyStimulus();
            checkOutput("fetch_word", if_rsp_data, words[i]);
        end
        if_req_valid = 1'b0;
        applyStimulus();

        $display("[TB] contention with both valid");
        if_req_valid = 1'b1; if_req_addr = 32'h20;
        ld_req_valid = 1'b1; ld_req_we = 1'b0; ld_req_addr = 32'h24;
        for (int k = 0; k < 10; k++) begin
            applyStimulus();
            checkOutput("contention_ld_grant", 32'(ld_rsp_valid), 32'(k % 5 == 4));
            checkOutput("contention_if_grant", 32'(if_rsp_valid), 32'(k % 5 != 4));
        end
        if_req_valid = 1'b0; ld_req_valid = 1'b0;
        applyStimulus();

        $display("[TB] lock, write and read back");
        ld_lock = 1'b1; if_req_valid = 1'b1; if_req_addr = 32'h40;
        applyStimulus();
        checkOutput("lock_rise_fetch_rsp", 32'(if_rsp_valid), 32'd1);
        ld_req_valid = 1'b1; ld_req_we = 1'b1; ld_req_addr = 32'h40; ld_req_wdata = 32'hDEADBEEF;
        applyStimulus();
        checkOutput("lock_write_rsp", ld_rsp_data, 32'd0);
        checkOutput("lock_stall", 32'(if_stall), 32'd1);
        ld_req_we = 1'b0;
        applyStimulus();
        checkOutput("lock_read_rsp", ld_rsp_data, 32'hDEADBEEF);
        ld_lock = 1'b0; ld_req_valid = 1'b0;
        applyStimulus();
        applyStimulus();
        checkOutput("unlock_fetch", if_rsp_data, 32'hDEADBEEF);
        if_req_valid = 1'b0;

        $display("[TB] out-of-range loader access");
        saved = tb_mem[0];
        ld_req_valid = 1'b1; ld_req_we = 1'b1; ld_req_addr = 32'h1000; ld_req_wdata = 32'h12345678;
        applyStimulus();
        checkOutput("oor_write_rsp_valid", 32'(ld_rsp_valid), 32'd1);
        checkOutput("oor_write_rsp_data", ld_rsp_data, 32'd0);
        checkOutput("oor_mem_unchanged", tb_mem[0], saved);
        ld_req_we = 1'b0; ld_req_addr = 32'h2004;
        applyStimulus();
        checkOutput("oor_read_rsp_data", ld_rsp_data, 32'd0);
        ld_req_valid = 1'b0;

        $display("[TB] misaligned fetch");
        if_req_valid = 1'b1; if_req_addr = 32'h43;
        applyStimulus();
        checkOutput("misaligned_fetch", if_rsp_data, 32'hDEADBEEF);

        $display("[TB] reset after fetch accept");
        if_req_addr = 32'h8;
        @(posedge clk);
        #1;
        rst = 1'b1; if_req_valid = 1'b0;
        #1;
        checkOutput("rst_drop_if_rsp", 32'(if_rsp_valid), 32'd0);
        checkOutput("rst_drop_if_data", if_rsp_data, 32'd0);
        checkOutput("rst_drop_mem_addr", 32'(mem_addr), 32'd0);
        checkOutput("rst_drop_mem_wdata", mem_wdata, 32'd0);
        checkOutput("rst_drop_stall", 32'(if_stall), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        lose = 0; locked = 1'b0; exp_if_v = 1'b0; exp_ld_v = 1'b0;
        if_req_valid = 1'b1; if_req_addr = 32'h4;
        applyStimulus();
        checkOutput("post_rst_fetch", if_rsp_data, words[1]);
        if_req_valid = 1'b0;
        applyStimulus();

        $display("[TB] randomized traffic");
        if_acc = 1'b1; ld_acc = 1'b1;
        for (int c = 0; c < 600; c++) begin
            if (!if_req_valid || if_acc) begin
                if_req_valid = ($urandom_range(0, 3) != 0);
                if_req_addr  = rand_addr();
            end
            if (!ld_req_valid || ld_acc) begin
                ld_req_valid = ($urandom_range(0, 2) == 0);
                ld_req_we    = $urandom_range(0, 1) == 1;
                ld_req_addr  = rand_addr();
                ld_req_wdata = $urandom;
            end
            if ($urandom_range(0, 24) == 0) ld_lock = !ld_lock;
            applyStimulus();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
